// File: rtl/spu_dual_issue.sv
// In-order dual-issue stage: holds one decoded pair, checks RAW/WAW/structural
// hazards against a latency scoreboard, steers issued slots to even/odd pipes.
// Optional build macro: FWD_EN (a source in its final pipe stage counts as ready).
module spu_dual_issue #(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 4,
  parameter int BW       = 79
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [BW-1:0] in_slot0,
  input  logic          in_slot0_v,
  input  logic [BW-1:0] in_slot1,
  input  logic          in_slot1_v,
  input  logic          flush,
  output logic [BW-1:0] out_even,
  output logic          out_even_valid,
  output logic [BW-1:0] out_odd,
  output logic          out_odd_valid,
  output logic          stall
);

  // Packed MSB-first, so full_instr sits in the top bits of the bundle.
  typedef struct packed {
    logic [31:0] full_instr;
    logic [6:0]  instr_id;
    logic [6:0]  reg_dst;
    logic [2:0]  unit_id;
    logic [3:0]  latency;
    logic        reg_wr;
    logic        pipe;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic        use_ra;
    logic        use_rb;
    logic        use_rc;
  } instr_t;

  typedef enum logic [1:0] {
    HS_EMPTY,
    HS_PAIR,
    HS_S1
  } hold_state_t;

  hold_state_t      state, state_nx;
  instr_t           s0_q, s1_q;
  logic             s1_held_q;
  logic [LAT_W-1:0] sb [NUM_REGS];

  instr_t in0, in1;
  assign in0 = in_slot0;
  assign in1 = in_slot1;

  function automatic logic src_ready(input logic [LAT_W-1:0] cnt);
`ifdef FWD_EN
    return cnt <= LAT_W'(1);
`else
    return cnt == '0;
`endif
  endfunction

  function automatic logic srcs_ok(input instr_t x, input logic [LAT_W-1:0] ca,
                                   input logic [LAT_W-1:0] cb, input logic [LAT_W-1:0] cc);
    return (!x.use_ra || src_ready(ca)) &&
           (!x.use_rb || src_ready(cb)) &&
           (!x.use_rc || src_ready(cc));
  endfunction

  // Slot1 reading a register that slot0 writes in the same pair.
  function automatic logic reads_dst(input instr_t older, input instr_t younger);
    return older.reg_wr &&
           ((younger.use_ra && younger.ra == older.reg_dst) ||
            (younger.use_rb && younger.rb == older.reg_dst) ||
            (younger.use_rc && younger.rc == older.reg_dst));
  endfunction

  logic ok0, ok1, pair_ok;
  logic iss0, iss1, all_issue, accept;

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    ok0       = 1'b0;
    ok1       = 1'b0;
    pair_ok   = 1'b0;
    iss0      = 1'b0;
    iss1      = 1'b0;
    all_issue = 1'b0;

    ok0 = srcs_ok(s0_q, sb[s0_q.ra], sb[s0_q.rb], sb[s0_q.rc]) &&
          (!s0_q.reg_wr || sb[s0_q.reg_dst] <= s0_q.latency);
    ok1 = srcs_ok(s1_q, sb[s1_q.ra], sb[s1_q.rb], sb[s1_q.rc]) &&
          (!s1_q.reg_wr || sb[s1_q.reg_dst] <= s1_q.latency);

    pair_ok = (s0_q.pipe != s1_q.pipe) && !reads_dst(s0_q, s1_q) &&
              !(s0_q.reg_wr && s1_q.reg_wr && s0_q.reg_dst == s1_q.reg_dst);

    if (!flush) begin
      unique case (state)
        HS_PAIR: begin
          iss0      = ok0;
          iss1      = s1_held_q && ok1 && ok0 && pair_ok;
          all_issue = iss0 && (!s1_held_q || iss1);
        end
        HS_S1: begin
          iss1      = ok1;
          all_issue = ok1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = !flush && (state == HS_EMPTY || all_issue);
  assign accept   = in_valid && in_ready;
  assign stall    = (state != HS_EMPTY) && !all_issue;

  always_comb begin
    state_nx = state;
    if (flush)
      state_nx = HS_EMPTY;
    else if (accept)
      state_nx = (in_slot0_v || in_slot1_v) ? HS_PAIR : HS_EMPTY;
    else if (all_issue)
      state_nx = HS_EMPTY;
    else if (state == HS_PAIR && iss0)
      state_nx = HS_S1;
  end

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= HS_EMPTY;
    else     state <= state_nx;
  end

  // A pair arriving with only slot1 present is shifted down into slot0.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q      <= '0;
      s1_q      <= '0;
      s1_held_q <= 1'b0;
    end else if (accept) begin
      if (in_slot0_v) begin
        s0_q      <= in0;
        s1_q      <= in1;
        s1_held_q <= in_slot1_v;
      end else begin
        s0_q      <= in1;
        s1_q      <= '0;
        s1_held_q <= 1'b0;
      end
    end
  end

  // NOTE: the scoreboard must be cleared on reset (unlike a plain data RAM),
  // because stale counts would block issue of unrelated instructions.
  // Later NBAs to the same entry win, so an issuing write overrides the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) sb[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++)
        if (sb[r] != '0) sb[r] <= sb[r] - LAT_W'(1);
      if (iss0 && s0_q.reg_wr) sb[s0_q.reg_dst] <= s0_q.latency;
      if (iss1 && s1_q.reg_wr) sb[s1_q.reg_dst] <= s1_q.latency;
    end
  end

  // Issuing slots never share a pipe, so each port sees at most one source.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_even       <= '0;
      out_even_valid <= 1'b0;
      out_odd        <= '0;
      out_odd_valid  <= 1'b0;
    end else begin
      out_even       <= '0;
      out_even_valid <= 1'b0;
      out_odd        <= '0;
      out_odd_valid  <= 1'b0;
      if (iss0 && !s0_q.pipe) begin
        out_even       <= s0_q;
        out_even_valid <= 1'b1;
      end else if (iss1 && !s1_q.pipe) begin
        out_even       <= s1_q;
        out_even_valid <= 1'b1;
      end
      if (iss0 && s0_q.pipe) begin
        out_odd       <= s0_q;
        out_odd_valid <= 1'b1;
      end else if (iss1 && s1_q.pipe) begin
        out_odd       <= s1_q;
        out_odd_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spu_dual_issue.sv
// Self-checking bench for spu_dual_issue: vector table for steady-state issue,
// hand sequences for structural, RAW, WAW, flush and reset corner cases.
module tb_spu_dual_issue;

  localparam int BW = 79;

  typedef struct packed {
    logic [31:0] full_instr;
    logic [6:0]  instr_id;
    logic [6:0]  reg_dst;
    logic [2:0]  unit_id;
    logic [3:0]  latency;
    logic        reg_wr;
    logic        pipe;
    logic [6:0]  ra;
    logic [6:0]  rb;
    logic [6:0]  rc;
    logic        use_ra;
    logic        use_rb;
    logic        use_rc;
  } instr_t;

  typedef struct {
    logic   in_valid;
    instr_t s0;
    logic   s0_v;
    instr_t s1;
    logic   s1_v;
    logic   exp_ready;
    logic   exp_stall;
    logic   exp_ev;
    instr_t exp_even;
    logic   exp_ov;
    instr_t exp_odd;
  } vec_t;

`ifdef FWD_EN
  localparam int EXP_RAW_STALLS   = 5;
  localparam int EXP_FLUSH_STALLS = 0;
`else
  localparam int EXP_RAW_STALLS   = 6;
  localparam int EXP_FLUSH_STALLS = 1;
`endif
  localparam int EXP_WAW_STALLS = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [BW-1:0] in_slot0;
  logic          in_slot0_v;
  logic [BW-1:0] in_slot1;
  logic          in_slot1_v;
  logic          flush;
  logic [BW-1:0] out_even;
  logic          out_even_valid;
  logic [BW-1:0] out_odd;
  logic          out_odd_valid;
  logic          stall;

  int n_tests = 0;
  int n_fail  = 0;

  spu_dual_issue dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_slot0       (in_slot0),
    .in_slot0_v     (in_slot0_v),
    .in_slot1       (in_slot1),
    .in_slot1_v     (in_slot1_v),
    .flush          (flush),
    .out_even       (out_even),
    .out_even_valid (out_even_valid),
    .out_odd        (out_odd),
    .out_odd_valid  (out_odd_valid),
    .stall          (stall)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic instr_t mk(input int id, input logic pipe, input logic wr,
                                input int dst, input int lat, input int ra);
    instr_t x;
    x            = '0;
    x.full_instr = 32'hC0DE_0000 | 32'(id);
    x.instr_id   = 7'(id);
    x.reg_dst    = 7'(dst);
    x.unit_id    = pipe ? 3'd5 : 3'd2;
    x.latency    = 4'(lat);
    x.reg_wr     = wr;
    x.pipe       = pipe;
    x.ra         = 7'(ra);
    x.rb         = 7'd99;
    x.rc         = 7'd100;
    x.use_ra     = 1'b1;
    return x;
  endfunction

  task automatic drive(input logic v, input instr_t a, input logic av,
                       input instr_t b, input logic bv);
    in_valid   = v;
    in_slot0   = a;
    in_slot0_v = av;
    in_slot1   = b;
    in_slot1_v = bv;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, '0, 1'b0);
    flush = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Counts consecutive stall cycles; checks the even port on the first one.
  task automatic count_stalls(input string name, input logic [BW-1:0] exp_first_even,
                              output int cnt);
    logic done;
    done = 1'b0;
    cnt  = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (k == 0) check({name, " first even"}, out_even, exp_first_even);
      if (stall) cnt++;
      else       done = 1'b1;
      next_cycle();
    end
    check({name, " timeout"}, done, 1);
  endtask

  vec_t   vt[10];
  instr_t z;
  instr_t a0, a1, b0, b1, c0, c1, d0, d1, e1, f0, f1;
  instr_t p0, p1, x0, y0, q0, q1, r0, w0, w1, v0, s0, s1;
  int     cnt;

  initial begin
    z  = '0;
    a0 = mk(1, 1'b0, 1'b1, 10, 3, 40);  a1 = mk(2, 1'b1, 1'b0, 0, 0, 41);
    b0 = mk(3, 1'b0, 1'b1, 11, 3, 42);  b1 = mk(4, 1'b1, 1'b1, 20, 2, 43);
    c0 = mk(5, 1'b0, 1'b1, 12, 3, 44);  c1 = mk(6, 1'b1, 1'b1, 21, 2, 45);
    d0 = mk(7, 1'b0, 1'b1, 13, 5, 46);  d1 = mk(8, 1'b1, 1'b0, 0, 0, 47);
    e1 = mk(9, 1'b1, 1'b0, 0, 0, 48);
    f0 = mk(10, 1'b0, 1'b0, 0, 0, 49);  f1 = mk(11, 1'b1, 1'b0, 0, 0, 49);

    //        vld   s0  s0v   s1  s1v   rdy   stl   ev    even  ov    odd
    vt[0] = '{1'b1, a0, 1'b1, a1, 1'b1, 1'b1, 1'b0, 1'b0, z,    1'b0, z };
    vt[1] = '{1'b1, b0, 1'b1, b1, 1'b1, 1'b1, 1'b0, 1'b0, z,    1'b0, z };
    vt[2] = '{1'b1, c0, 1'b1, c1, 1'b1, 1'b1, 1'b0, 1'b1, a0,   1'b1, a1};
    vt[3] = '{1'b1, d0, 1'b1, d1, 1'b1, 1'b1, 1'b0, 1'b1, b0,   1'b1, b1};
    vt[4] = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, 1'b0, 1'b1, c0,   1'b1, c1};
    vt[5] = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, 1'b0, 1'b1, d0,   1'b1, d1};
    vt[6] = '{1'b1, z,  1'b0, e1, 1'b1, 1'b1, 1'b0, 1'b0, z,    1'b0, z };
    vt[7] = '{1'b1, f0, 1'b0, f1, 1'b0, 1'b1, 1'b0, 1'b0, z,    1'b0, z };
    vt[8] = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, 1'b0, 1'b0, z,    1'b1, e1};
    vt[9] = '{1'b0, z,  1'b0, z,  1'b0, 1'b1, 1'b0, 1'b0, z,    1'b0, z };

    // Reset state
    reset_dut();
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset stall", stall, 0);
    check("reset even_valid", out_even_valid, 0);
    check("reset odd_valid", out_odd_valid, 0);
    check("reset out_even", out_even, '0);
    check("reset out_odd", out_odd, '0);
    next_cycle();

    // Back-to-back independent pairs, slot1-only pair, empty pair
    for (int i = 0; i < 10; i++) begin
      drive(vt[i].in_valid, vt[i].s0, vt[i].s0_v, vt[i].s1, vt[i].s1_v);
      @(negedge clk);
      check($sformatf("vec%0d in_ready", i), in_ready, vt[i].exp_ready);
      check($sformatf("vec%0d stall", i), stall, vt[i].exp_stall);
      check($sformatf("vec%0d even_valid", i), out_even_valid, vt[i].exp_ev);
      check($sformatf("vec%0d out_even", i), out_even, vt[i].exp_even);
      check($sformatf("vec%0d odd_valid", i), out_odd_valid, vt[i].exp_ov);
      check($sformatf("vec%0d out_odd", i), out_odd, vt[i].exp_odd);
      next_cycle();
    end
    idle();

    // Both slots even: serialised over two cycles
    reset_dut();
    s0 = mk(20, 1'b0, 1'b0, 0, 0, 50);
    s1 = mk(21, 1'b0, 1'b0, 0, 0, 51);
    drive(1'b1, s0, 1'b1, s1, 1'b1);
    @(negedge clk);
    check("struct accept ready", in_ready, 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("struct c1 stall", stall, 1);
    check("struct c1 ready", in_ready, 0);
    next_cycle();
    @(negedge clk);
    check("struct c2 stall", stall, 0);
    check("struct c2 ready", in_ready, 1);
    check("struct c2 out_even", out_even, s0);
    check("struct c2 odd_valid", out_odd_valid, 0);
    next_cycle();
    @(negedge clk);
    check("struct c3 out_even", out_even, s1);
    check("struct c3 even_valid", out_even_valid, 1);
    next_cycle();

    // RAW: slot1 reads r5 written by slot0 with latency 6
    reset_dut();
    p0 = mk(30, 1'b0, 1'b1, 5, 6, 52);
    p1 = mk(31, 1'b1, 1'b0, 0, 0, 5);
    drive(1'b1, p0, 1'b1, p1, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("raw issue-cycle stall", stall, 1);
    next_cycle();
    count_stalls("raw", p0, cnt);
    check("raw stall cycles", cnt, EXP_RAW_STALLS);
    @(negedge clk);
    check("raw out_odd", out_odd, p1);
    check("raw odd_valid", out_odd_valid, 1);
    next_cycle();

    // WAW: r9 in flight with 7 cycles left, new writer of r9 with latency 2
    reset_dut();
    x0 = mk(32, 1'b0, 1'b1, 9, 7, 53);
    y0 = mk(33, 1'b1, 1'b1, 9, 2, 54);
    drive(1'b1, x0, 1'b1, z, 1'b0);
    next_cycle();
    drive(1'b1, y0, 1'b1, z, 1'b0);
    @(negedge clk);
    check("waw accept ready", in_ready, 1);
    next_cycle();
    idle();
    count_stalls("waw", x0, cnt);
    check("waw stall cycles", cnt, EXP_WAW_STALLS);
    @(negedge clk);
    check("waw out_odd", out_odd, y0);
    next_cycle();

    // Flush while only slot1 is held; r3 write still blocks a later reader
    reset_dut();
    q0 = mk(40, 1'b0, 1'b1, 3, 4, 55);
    q1 = mk(41, 1'b0, 1'b0, 0, 0, 3);
    r0 = mk(42, 1'b1, 1'b0, 0, 0, 3);
    drive(1'b1, q0, 1'b1, q1, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("flush c1 stall", stall, 1);
    next_cycle();
    @(negedge clk);
    check("flush c2 stall", stall, 1);
    check("flush c2 out_even", out_even, q0);
    next_cycle();
    flush = 1'b1;
    drive(1'b1, r0, 1'b1, z, 1'b0);
    @(negedge clk);
    check("flush cycle ready", in_ready, 0);
    next_cycle();
    flush = 1'b0;
    @(negedge clk);
    check("post-flush ready", in_ready, 1);
    check("post-flush even_valid", out_even_valid, 0);
    check("post-flush odd_valid", out_odd_valid, 0);
    next_cycle();
    idle();
    count_stalls("flush reader", z, cnt);
    check("flush reader stall cycles", cnt, EXP_FLUSH_STALLS);
    @(negedge clk);
    check("flush reader out_odd", out_odd, r0);
    next_cycle();

    // Reset in the middle of a stall
    reset_dut();
    w0 = mk(60, 1'b0, 1'b1, 7, 15, 56);
    w1 = mk(61, 1'b1, 1'b0, 0, 0, 7);
    v0 = mk(62, 1'b1, 1'b0, 0, 0, 7);
    drive(1'b1, w0, 1'b1, w1, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("rst pre stall", stall, 1);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    drive(1'b1, v0, 1'b1, z, 1'b0);
    @(negedge clk);
    check("rst after even_valid", out_even_valid, 0);
    check("rst after odd_valid", out_odd_valid, 0);
    check("rst after ready", in_ready, 1);
    check("rst after stall", stall, 0);
    next_cycle();
    idle();
    @(negedge clk);
    check("rst reader no stall", stall, 0);
    next_cycle();
    @(negedge clk);
    check("rst reader out_odd", out_odd, v0);
    check("rst reader even_valid", out_even_valid, 0);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
